hb_period_avg: RTL



---
 rtl/wd_pkg.sv | 21 ++
 rtl/hb_sync_edge.sv | 28 ++
 rtl/hb_period_avg.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wd_pkg.sv
// Shared watchdog datapath definitions: Q(F) defaults,
// averager FSM states and the signed Q(F) saturation limit.
package wd_pkg;

  localparam int W_DEF = 32;
  localparam int F_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } hbp_st_t;

  function automatic logic [63:0] q_sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  localparam logic [W_DEF-1:0] Q_SAT_MAX =
    W_DEF'(q_sat_max(W_DEF));

endpackage

// File: rtl/hb_sync_edge.sv
// Two-flop synchroniser for an asynchronous input followed
// by a registered rising-edge detector (one-cycle pulse).
module hb_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/hb_period_avg.sv
// Heartbeat period averager: measures cycles between heartbeat
// edges, averages over DEPTH samples, feeds the reciprocal stage.
module hb_period_avg
  import wd_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int F     = F_DEF,
  parameter int CNT_W = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hb_in,
  input  logic         calc_done,
  output logic [W-1:0] period_q,
  output logic         start_calc,
  output logic         busy,
  output logic         stall
);

  localparam int LG = $clog2(DEPTH);
  localparam int SW = CNT_W + LG;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LG:0] FULL = (LG + 1)'(DEPTH);
  localparam logic [63:0] SAT_LIM = 64'd1 << (W - 1 - F);
  localparam logic [W-1:0] QMAX = W'(q_sat_max(W));

  logic             hb_evt;
  logic             armed;
  logic             sample;
  logic             pend;
  logic             issue;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] avg;
  logic [SW-1:0]    sum;
  logic [LG-1:0]    wp;
  logic [LG:0]      fill;
  logic [CNT_W-1:0] ring [DEPTH];
  logic [W-1:0]     scaled;
  hbp_st_t          st;

  hb_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (hb_in),
    .rise     (hb_evt)
  );

  // first edge after reset only arms the counter
  assign sample = hb_evt & armed;
  assign avg    = sum[SW-1:LG];
  assign scaled = (64'(avg) >= SAT_LIM) ? QMAX
                : W'(64'(avg) << F);
  assign issue  = (st == S_IDLE) && pend && (fill == FULL);
  assign stall  = armed && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      wp    <= '0;
      fill  <= '0;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else begin
      if (hb_evt) begin
        armed <= 1'b1;
        cnt   <= CNT_W'(1);
      end else if (armed && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (sample) begin
        ring[wp] <= cnt;
        sum      <= sum + SW'(cnt) - SW'(ring[wp]);
        wp       <= wp + LG'(1);
        if (fill != FULL) fill <= fill + (LG + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      pend       <= 1'b0;
      period_q   <= '0;
      start_calc <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // a sample landing in the issuing cycle re-arms pend
      if (sample)     pend <= 1'b1;
      else if (issue) pend <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (issue) begin
            period_q   <= scaled;
            start_calc <= 1'b1;
            busy       <= 1'b1;
            st         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_calc <= 1'b0;
          st         <= S_WAIT;
        end
        S_WAIT: begin
          if (calc_done) begin
            busy <= 1'b0;
            st   <= S_IDLE;
          end
        end
        default: begin
          start_calc <= 1'b0;
          busy       <= 1'b0;
          st         <= S_IDLE;
        end
      endcase
    end
  end

endmodule
